// File: rtl/load_store_unit_if.sv
// Single-port data memory bus: request/write strobe, word address, lane data and read return.
// Master side is the load/store unit; slave side is the memory.
`default_nettype none

interface load_store_unit_if #(
  parameter int ADDR_W = 8
) ();
  logic              request;
  logic              we_re;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [3:0]        mask;
  logic              valid;
  logic [31:0]       data_out;

  modport master (
    output request, we_re, address, data_in, mask,
    input  valid, data_out
  );

  modport slave (
    input  request, we_re, address, data_in, mask,
    output valid, data_out
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for the single-port data memory; stalls the core until done.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses complete with err and no memory request.
`default_nettype none

module load_store_unit #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  wire logic        clk_i,
  input  wire logic        rst_ni,
  input  wire logic        start_i,
  input  wire logic        is_store_i,
  input  wire logic [2:0]  funct3_i,
  input  wire logic [31:0] eff_addr_i,
  input  wire logic [31:0] store_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      load_data_o,
  load_store_unit_if.master mem_if
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic              busy_q, done_q, err_q, request_q, we_q, signed_q;
  logic [1:0]        size_q, off_q;
  logic [ADDR_W-1:0] address_q;
  logic [31:0]       data_in_q, load_data_q;
  logic [3:0]        mask_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0]  size_d, off_d;
  logic [3:0]  mask_d;
  logic [31:0] data_in_d, load_ext;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        misaligned;
  logic        addr_unused;

  assign addr_unused = ^eff_addr_i[31:ADDR_W+2];

  // Reserved funct3 codes 011/110/111 fall through to word size.
  always_comb begin
    size_d = SZ_W;
    if (funct3_i[1:0] == 2'b00) size_d = SZ_B;
    else if (funct3_i[1:0] == 2'b01) size_d = SZ_H;
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((size_d == SZ_H) && eff_addr_i[0]) ||
                      ((size_d == SZ_W) && (eff_addr_i[1:0] != 2'b00));
  assign off_d      = eff_addr_i[1:0];
`else
  assign misaligned = 1'b0;
  assign off_d      = (size_d == SZ_W) ? 2'b00 :
                      (size_d == SZ_H) ? {eff_addr_i[1], 1'b0} : eff_addr_i[1:0];
`endif

  always_comb begin
    mask_d    = 4'b1111;
    data_in_d = store_data_i;
    case (size_d)
      SZ_B: begin
        mask_d    = 4'b0001 << off_d;
        data_in_d = {4{store_data_i[7:0]}};
      end
      SZ_H: begin
        mask_d    = 4'b0011 << off_d;
        data_in_d = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_byte = mem_if.data_out[{off_q, 3'b000} +: 8];
    sel_half = mem_if.data_out[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_B:    load_ext = {{24{signed_q & sel_byte[7]}}, sel_byte};
      SZ_H:    load_ext = {{16{signed_q & sel_half[15]}}, sel_half};
      default: load_ext = mem_if.data_out;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      request_q   <= 1'b0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= SZ_W;
      off_q       <= 2'b00;
      address_q   <= '0;
      data_in_q   <= '0;
      mask_q      <= '0;
      load_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      request_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          busy_q    <= 1'b1;
          we_q      <= is_store_i;
          signed_q  <= ~funct3_i[2];
          size_q    <= size_d;
          off_q     <= off_d;
          address_q <= eff_addr_i[ADDR_W+1:2];
          data_in_q <= data_in_d;
          mask_q    <= mask_d;
          if (misaligned) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q   <= S_REQ;
            request_q <= 1'b1;
          end
        end
        S_REQ: begin
          cnt_q <= '0;
          if (we_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        // valid is sticky in the memory, so it is only trusted while waiting here.
        S_WAIT: begin
          if (mem_if.valid) begin
            load_data_q <= load_ext;
            state_q     <= S_DONE;
            done_q      <= 1'b1;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            load_data_q <= '0;
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign load_data_o    = load_data_q;
  assign mem_if.request = request_q;
  assign mem_if.we_re   = we_q;
  assign mem_if.address = address_q;
  assign mem_if.data_in = data_in_q;
  assign mem_if.mask    = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural memory and an expected-result queue.
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] eff_addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, err;
  logic [31:0] load_data;

  int errors = 0;
  int checks = 0;

  logic        mute = 1'b0;
  bit   [31:0] mem [256];
  int          req_cnt = 0;
  logic [7:0]  last_addr;
  logic        last_we;
  logic [3:0]  last_mask;
  logic [31:0] last_din;

  typedef struct {
    logic [31:0] ld;
    logic        err;
    int          lat;
  } sb_t;
  sb_t sb_q[$];

  load_store_unit_if #(.ADDR_W(8)) bus ();

  load_store_unit #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start),
    .is_store_i   (is_store),
    .funct3_i     (funct3),
    .eff_addr_i   (eff_addr),
    .store_data_i (store_data),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .load_data_o  (load_data),
    .mem_if       (bus.master)
  );

  always #5 clk = ~clk;

  // Memory: updates at the request edge, valid stays high after any read.
  always @(posedge clk) begin
    if (!rst_ni) begin
      bus.valid    <= 1'b0;
      bus.data_out <= '0;
    end else begin
      if (mute) bus.valid <= 1'b0;
      if (bus.request) begin
        req_cnt   = req_cnt + 1;
        last_addr = bus.address;
        last_we   = bus.we_re;
        last_mask = bus.mask;
        last_din  = bus.data_in;
        if (bus.we_re) begin
          for (int b = 0; b < 4; b++)
            if (bus.mask[b]) mem[bus.address][8*b +: 8] = bus.data_in[8*b +: 8];
        end else begin
          bus.data_out <= mem[bus.address];
          if (!mute) bus.valid <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] eld, input logic eerr, input int elat);
    sb_t e;
    int  lat;
    e.ld = eld; e.err = eerr; e.lat = elat;
    sb_q.push_back(e);
    is_store = st; funct3 = f3; eff_addr = a; store_data = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check({tag, ".busy"}, {31'b0, busy}, 32'd1);
    while (!done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    check({tag, ".done"}, {31'b0, done}, 32'd1);
    check({tag, ".latency"}, lat, e.lat);
    check({tag, ".err"}, {31'b0, err}, {31'b0, e.err});
    check({tag, ".load_data"}, load_data, e.ld);
    @(posedge clk); #1;
    check({tag, ".idle"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int n;
    #12;
    check("reset.ctrl", {27'b0, busy, done, err, bus.request, bus.we_re}, 32'd0);
    check("reset.addr_mask", {20'b0, bus.address, bus.mask}, 32'd0);
    check("reset.data_in", bus.data_in, 32'd0);
    check("reset.load_data", load_data, 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    access("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("sw10.req", {16'b0, last_addr, 3'b0, last_we, last_mask}, {16'b0, 8'h04, 3'b0, 1'b1, 4'hF});
    check("sw10.din", last_din, 32'hDEADBEEF);

    access("sb13", 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, 2);
    check("sb13.mask", {28'b0, last_mask}, 32'h8);
    check("sb13.din", last_din, 32'hA5A5A5A5);
    access("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 3);

    access("sh16", 1'b1, 3'b001, 32'h16, 32'hCAFE1234, 32'hA5ADBEEF, 1'b0, 2);
    check("sh16.mask", {28'b0, last_mask}, 32'hC);
    check("sh16.din", last_din, 32'h12341234);
    access("lw14", 1'b0, 3'b010, 32'h14, 32'h0, 32'h12340000, 1'b0, 3);

    access("sw20", 1'b1, 3'b010, 32'h20, 32'h8001F07F, 32'h12340000, 1'b0, 2);
    access("lb20", 1'b0, 3'b000, 32'h20, 32'h0, 32'h0000007F, 1'b0, 3);
    access("lb23", 1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    access("lhu22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0, 3);
    access("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 3);
    access("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h000000F0, 1'b0, 3);
    access("f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h8001F07F, 1'b0, 3);
    access("lh20", 1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFFF07F, 1'b0, 3);
    check("lh20.addr", {24'b0, last_addr}, 32'h08);

    n = req_cnt;
`ifdef MISALIGN_TRAP_EN
    access("lw22", 1'b0, 3'b010, 32'h22, 32'h0, 32'hFFFFF07F, 1'b1, 1);
    check("lw22.no_req", req_cnt - n, 32'd0);
`else
    access("lw22", 1'b0, 3'b010, 32'h22, 32'h0, 32'h8001F07F, 1'b0, 3);
    check("lw22.one_req", req_cnt - n, 32'd1);
    check("lw22.addr", {24'b0, last_addr}, 32'h08);
`endif

    mute = 1'b1;
    access("timeout", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b1, 18);

    is_store = 1'b0; funct3 = 3'b010; eff_addr = 32'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    check("rst_wait.ctrl", {29'b0, bus.request, busy, done}, 32'd0);
    @(posedge clk); #1;
    check("rst_wait.held", {29'b0, bus.request, busy, done}, 32'd0);
    rst_ni = 1'b1;
    mute = 1'b0;
    @(posedge clk); #1;
    access("post_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
